button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 19 +
 rtl/button_conditioner_debounce_channel.sv | 117 +++++++++++
 rtl/button_conditioner.sv | 48 ++++
 tb/tb_button_conditioner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants for the push-button front end.
// The five button levels travel as one packed buttons_t bus.
package button_conditioner_pkg;

    localparam int BUTTON_COUNT            = 5;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_REPEAT_DELAY    = 50000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    typedef struct packed {
        logic center;
        logic up;
        logic right;
        logic down;
        logic left;
    } buttons_t;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button: synchroniser, stable-level debouncer, press/release pulses.
// Optional auto-repeat of the press pulse when BUTTON_AUTOREPEAT_EN is defined.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;
    logic                   s;
    logic                   rise;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        s       = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        cnt_d   = cnt_q + CNT_W'(1);
        // Any cycle agreeing with the stable level restarts qualification.
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end
        rise       = level_d & ~level_q;
        released_d = ~level_d & level_q;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_hit;

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
        rpt_first_d = rpt_first_q;
        rpt_hit     = 1'b0;
        if (!level_q || rise) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST)) begin
            // Gated by level_d so a release in this cycle wins over a repeat.
            rpt_hit     = level_d;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end
        pressed_d = rise | rpt_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    always_comb begin
        pressed_d = rise;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign level    = level_q;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five raw board buttons into clean levels plus press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic     clock_100mhz,
    input  logic     reset,
    input  buttons_t raw_buttons,
    output buttons_t buttons,
    output buttons_t pressed,
    output buttons_t released,
    output logic     any_held
);

    logic [BUTTON_COUNT-1:0] raw_vec;
    logic [BUTTON_COUNT-1:0] level_vec;
    logic [BUTTON_COUNT-1:0] press_vec;
    logic [BUTTON_COUNT-1:0] release_vec;

    assign raw_vec = raw_buttons;

    for (genvar gi = 0; gi < BUTTON_COUNT; gi++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clock_100mhz),
            .rst     (reset),
            .raw     (raw_vec[gi]),
            .level   (level_vec[gi]),
            .pressed (press_vec[gi]),
            .released(release_vec[gi])
        );
    end

    assign buttons  = buttons_t'(level_vec);
    assign pressed  = buttons_t'(press_vec);
    assign released = buttons_t'(release_vec);
    assign any_held = |level_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce and repeat timing.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam logic [4:0] B_CENTER = 5'b10000;
    localparam logic [4:0] B_UP     = 5'b01000;
    localparam logic [4:0] B_RIGHT  = 5'b00100;
    localparam logic [4:0] B_DOWN   = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00001;
    localparam logic [4:0] B_NONE   = 5'b00000;

    logic     clock_100mhz;
    logic     reset;
    buttons_t raw_buttons;
    buttons_t buttons;
    buttons_t pressed;
    buttons_t released;
    logic     any_held;

    int total;
    int bad;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] b;
        logic [4:0] p;
        logic [4:0] r;
        string      name;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock_100mhz(clock_100mhz),
        .reset       (reset),
        .raw_buttons (raw_buttons),
        .buttons     (buttons),
        .pressed     (pressed),
        .released    (released),
        .any_held    (any_held)
    );

    initial clock_100mhz = 1'b0;
    always #5 clock_100mhz = ~clock_100mhz;

    task automatic compare(input logic [4:0] eb, input logic [4:0] ep,
                           input logic [4:0] er, input string name, input int step);
        logic [4:0] gb, gp, gr;
        gb = buttons;
        gp = pressed;
        gr = released;
        total++;
        if (gb !== eb || gp !== ep || gr !== er || any_held !== (|eb)) begin
            bad++;
            $display("FAIL %s step %0d: got b=%b p=%b r=%b any=%b, want b=%b p=%b r=%b any=%b",
                     name, step, gb, gp, gr, any_held, eb, ep, er, |eb);
        end else begin
            $display("chk %s step %0d: b=%b p=%b r=%b any=%b ok", name, step, gb, gp, gr, any_held);
        end
    endtask

    task automatic tick(input logic [4:0] rv, input logic [4:0] eb, input logic [4:0] ep,
                        input logic [4:0] er, input string name, input int step);
        raw_buttons = buttons_t'(rv);
        @(posedge clock_100mhz);
        #1;
        compare(eb, ep, er, name, step);
    endtask

    task automatic add_vec(input logic [4:0] rv, input logic [4:0] eb, input logic [4:0] ep,
                           input logic [4:0] er, input string name);
        vecs[nvec].raw  = rv;
        vecs[nvec].b    = eb;
        vecs[nvec].p    = ep;
        vecs[nvec].r    = er;
        vecs[nvec].name = name;
        nvec++;
    endtask

    function automatic logic [4:0] sel(input bit c, input logic [4:0] v);
        return c ? v : B_NONE;
    endfunction

    function automatic bit repeat_pulse(input int j);
`ifdef BUTTON_AUTOREPEAT_EN
        return (j >= 13) && (j < 35) && (((j - 13) % 3) == 0);
`else
        return (j < 0);
`endif
    endfunction

    initial begin
        logic [4:0] rv;
        total = 0;
        bad   = 0;
        nvec  = 0;

        // Single press/release of up: accept 6 edges after raw change, i.e. step 5 here.
        for (int j = 0; j < 15; j++)
            add_vec(sel(j < 8, B_UP), sel(j >= 5 && j < 13, B_UP),
                    sel(j == 5, B_UP), sel(j == 13, B_UP), "up_single");
        // Center bounces 1,0,1,0 then holds; final rise raw at step 4 accepted at step 9.
        for (int j = 0; j < 18; j++) begin
            case (j)
                0, 2:    rv = B_CENTER;
                1, 3:    rv = B_NONE;
                default: rv = (j < 11) ? B_CENTER : B_NONE;
            endcase
            add_vec(rv, sel(j >= 9 && j < 16, B_CENTER),
                    sel(j == 9, B_CENTER), sel(j == 16, B_CENTER), "center_bounce");
        end

        raw_buttons = buttons_t'(B_NONE);
        reset       = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clock_100mhz);
            #1;
            compare(B_NONE, B_NONE, B_NONE, "in_reset", j);
        end
        reset = 1'b0;

        for (int j = 0; j < 10; j++)
            tick(B_NONE, B_NONE, B_NONE, B_NONE, "idle", j);

        for (int k = 0; k < nvec; k++)
            tick(vecs[k].raw, vecs[k].b, vecs[k].p, vecs[k].r, vecs[k].name, k);

        // Up and left together, left released after 20 held cycles, then up released.
        for (int j = 0; j < 41; j++) begin
            if (j < 25)      rv = B_UP | B_LEFT;
            else if (j < 34) rv = B_UP;
            else             rv = B_NONE;
            tick(rv,
                 (j < 5) ? B_NONE : (j < 30) ? (B_UP | B_LEFT) : (j < 39) ? B_UP : B_NONE,
                 sel(j == 5, B_UP | B_LEFT),
                 (j == 30) ? B_LEFT : (j == 39) ? B_UP : B_NONE,
                 "up_left", j);
        end

        // Up accepted, then down counting to 3 when reset hits.
        for (int j = 0; j < 7; j++)
            tick(B_UP, sel(j >= 5, B_UP), sel(j == 5, B_UP), B_NONE, "pre_reset_up", j);
        for (int j = 0; j < 5; j++)
            tick(B_UP | B_DOWN, B_UP, B_NONE, B_NONE, "down_counting", j);
        reset = 1'b1;
        #1;
        compare(B_NONE, B_NONE, B_NONE, "async_clear", 0);
        @(posedge clock_100mhz);
        @(posedge clock_100mhz);
        #1;
        compare(B_NONE, B_NONE, B_NONE, "reset_held", 1);
        reset = 1'b0;
        for (int j = 0; j < 8; j++)
            tick(B_UP | B_DOWN, sel(j >= 5, B_UP | B_DOWN), sel(j == 5, B_UP | B_DOWN),
                 B_NONE, "requalify", j);
        for (int j = 0; j < 7; j++)
            tick(B_NONE, sel(j < 5, B_UP | B_DOWN), B_NONE, sel(j == 5, B_UP | B_DOWN),
                 "post_reset_release", j);

        // Right held 30 cycles: accept at 5, repeats (if enabled) at 13 then every 3.
        for (int j = 0; j < 41; j++)
            tick(sel(j < 30, B_RIGHT), sel(j >= 5 && j < 35, B_RIGHT),
                 sel(j == 5 || repeat_pulse(j), B_RIGHT), sel(j == 35, B_RIGHT),
                 "right_hold", j);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
